// File: rtl/ula_sequenciador.sv
// Issuing side of the ALU interface: hands the function code to the ALU, writes the result back,
// keeps the architectural {Z,C,S,O} flag register and resolves jumps against it.
//
// state   | meaning
// OCIOSO  | idle, inst_ready=1, waiting for an instruction
// EXECUTA | ALU computing, controle = captured op; result and flags sampled on exit
// GRAVA   | reg_we strobe for the sampled result
// AVALIA  | jump decision presented on desvio_valido/desvio_tomado
module ula_sequenciador #(
  parameter int bits_palavra  = 16,
  parameter int bits_controle = 5,
  parameter int bits_end      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [1:0]               inst_tipo,
  input  logic [bits_controle-1:0] inst_op,
  input  logic [2:0]               inst_cond,
  input  logic [bits_end-1:0]      inst_rd,
  output logic [bits_controle-1:0] controle,
  input  logic [bits_palavra-1:0]  resultadoOp,
  input  logic                     Z,
  input  logic                     C,
  input  logic                     S,
  input  logic                     O,
  output logic                     reg_we,
  output logic [bits_end-1:0]      reg_end,
  output logic [bits_palavra-1:0]  reg_dado,
  output logic [3:0]               flags,
  output logic                     desvio_valido,
  output logic                     desvio_tomado,
  output logic                     erro_op
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, GRAVA, AVALIA} estado_t;

  localparam logic [1:0] TIPO_ULA     = 2'b00;
  localparam logic [1:0] TIPO_CONDIC  = 2'b01;
  localparam logic [1:0] TIPO_INCOND  = 2'b10;
  localparam logic [bits_controle-1:0] CTRL_OCIOSO = {1'b1, {(bits_controle-1){1'b0}}};

  estado_t                  estado, estado_prox;
  logic [bits_controle-1:0] op_q;
  logic [2:0]               cond_q;
  logic [bits_end-1:0]      rd_q;
  logic                     incond_q;
  logic [3:0]               flags_q;
  logic [bits_end-1:0]      reg_end_q;
  logic [bits_palavra-1:0]  reg_dado_q;
  logic                     erro_q;
  logic                     aceita;
  logic                     op_valido;
  logic [4:0]               op_dec;

  assign inst_ready = (estado == OCIOSO);
  assign aceita     = inst_valid && inst_ready;
  assign op_dec     = inst_op[4:0];

  // Holes in the function-code map: 00010, 00111 and 01010..01111.
  always_comb begin
    op_valido = 1'b1;
    if (op_dec == 5'b00010 || op_dec == 5'b00111)
      op_valido = 1'b0;
    else if (op_dec[4:3] == 2'b01 && op_dec[2:1] != 2'b00)
      op_valido = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= OCIOSO;
      op_q       <= CTRL_OCIOSO;
      cond_q     <= 3'b000;
      rd_q       <= '0;
      incond_q   <= 1'b0;
      flags_q    <= 4'b0000;
      reg_end_q  <= '0;
      reg_dado_q <= '0;
      erro_q     <= 1'b0;
    end else begin
      estado <= estado_prox;
      erro_q <= aceita && (inst_tipo == TIPO_ULA) && !op_valido;
      if (aceita) begin
        op_q     <= inst_op;
        cond_q   <= inst_cond;
        rd_q     <= inst_rd;
        incond_q <= (inst_tipo == TIPO_INCOND);
      end
      if (estado == EXECUTA) begin
        reg_dado_q <= resultadoOp;
        reg_end_q  <= rd_q;
        // Logic ops clear C and O; shifts only clear O.
        if (op_q[4])
          flags_q <= {Z, 1'b0, S, 1'b0};
        else if (op_q[3])
          flags_q <= {Z, C, S, 1'b0};
        else
          flags_q <= {Z, C, S, O};
      end
    end
  end

  always_comb begin
    estado_prox = estado;
    controle    = CTRL_OCIOSO;
    case (estado)
      OCIOSO: begin
        if (aceita) begin
          case (inst_tipo)
            TIPO_ULA:    if (op_valido) estado_prox = EXECUTA;
            TIPO_CONDIC: estado_prox = AVALIA;
            TIPO_INCOND: estado_prox = AVALIA;
            default:     estado_prox = OCIOSO;
          endcase
        end
      end
      EXECUTA: begin
        controle    = op_q;
        estado_prox = GRAVA;
      end
      GRAVA:   estado_prox = OCIOSO;
      AVALIA:  estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_comb begin
    desvio_tomado = 1'b0;
    if (estado == AVALIA) begin
      if (incond_q) begin
        desvio_tomado = 1'b1;
      end else begin
        case (cond_q)
          3'b000:  desvio_tomado = 1'b1;
          3'b001:  desvio_tomado = flags_q[3];
          3'b010:  desvio_tomado = !flags_q[3];
          3'b011:  desvio_tomado = flags_q[1];
          3'b100:  desvio_tomado = !flags_q[1];
          3'b101:  desvio_tomado = flags_q[2];
          3'b110:  desvio_tomado = flags_q[0];
          default: desvio_tomado = flags_q[1] ^ flags_q[0];
        endcase
      end
    end
  end

  assign desvio_valido = (estado == AVALIA);
  assign reg_we        = (estado == GRAVA);
  assign reg_end       = reg_end_q;
  assign reg_dado      = reg_dado_q;
  assign flags         = flags_q;
  assign erro_op       = erro_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed table of instructions with hand-computed results, plus reset and mid-operation abort sequences.
module tb_ula_sequenciador;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  inst_tipo;
  logic [4:0]  inst_op;
  logic [2:0]  inst_cond;
  logic [3:0]  inst_rd;
  logic [4:0]  controle;
  logic [15:0] resultadoOp;
  logic        Z, C, S, O;
  logic        reg_we;
  logic [3:0]  reg_end;
  logic [15:0] reg_dado;
  logic [3:0]  flags;
  logic        desvio_valido;
  logic        desvio_tomado;
  logic        erro_op;

  int checks = 0;
  int errors = 0;

  ula_sequenciador dut (
    .clock(clock), .reset(reset),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_tipo(inst_tipo), .inst_op(inst_op), .inst_cond(inst_cond), .inst_rd(inst_rd),
    .controle(controle), .resultadoOp(resultadoOp),
    .Z(Z), .C(C), .S(S), .O(O),
    .reg_we(reg_we), .reg_end(reg_end), .reg_dado(reg_dado), .flags(flags),
    .desvio_valido(desvio_valido), .desvio_tomado(desvio_tomado), .erro_op(erro_op)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  tipo;
    logic [4:0]  op;
    logic [2:0]  cond;
    logic [3:0]  rd;
    logic [15:0] res;
    logic [3:0]  zcso;
    logic [3:0]  exp_flags;
    logic        exp_tomado;
    logic        exp_erro;
  } vetor_t;

  localparam int NV = 25;
  vetor_t vecs [NV];

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic aplica(input vetor_t v);
    @(negedge clock);
    inst_valid  = 1'b1;
    inst_tipo   = v.tipo;
    inst_op     = v.op;
    inst_cond   = v.cond;
    inst_rd     = v.rd;
    resultadoOp = v.res;
    {Z, C, S, O} = v.zcso;
    @(posedge clock);
    #1;
    inst_valid = 1'b0;
    if (v.tipo == 2'b00 && !v.exp_erro) begin
      chk("execute controle", controle, v.op);
      chk("execute ready", inst_ready, 1'b0);
      chk("execute we", reg_we, 1'b0);
      // Offer a scrambled instruction while busy; it must be ignored.
      inst_valid = 1'b1;
      inst_tipo  = 2'b01;
      inst_op    = ~v.op;
      inst_rd    = ~v.rd;
      @(posedge clock);
      #1;
      inst_valid = 1'b0;
      chk("grava we", reg_we, 1'b1);
      chk("grava end", reg_end, v.rd);
      chk("grava dado", reg_dado, v.res);
      chk("grava flags", flags, v.exp_flags);
      chk("grava controle", controle, 5'b10000);
      @(posedge clock);
      #1;
      chk("post we", reg_we, 1'b0);
      chk("post ready", inst_ready, 1'b1);
      chk("post valido", desvio_valido, 1'b0);
    end else if (v.tipo == 2'b00) begin
      chk("erro pulse", erro_op, 1'b1);
      chk("erro ready", inst_ready, 1'b1);
      chk("erro we", reg_we, 1'b0);
      chk("erro flags", flags, v.exp_flags);
      @(posedge clock);
      #1;
      chk("erro end", erro_op, 1'b0);
      chk("erro we2", reg_we, 1'b0);
      chk("erro flags2", flags, v.exp_flags);
    end else if (v.tipo == 2'b11) begin
      chk("nop ready", inst_ready, 1'b1);
      chk("nop we", reg_we, 1'b0);
      chk("nop valido", desvio_valido, 1'b0);
      chk("nop erro", erro_op, 1'b0);
      chk("nop flags", flags, v.exp_flags);
    end else begin
      chk("desvio valido", desvio_valido, 1'b1);
      chk("desvio tomado", desvio_tomado, v.exp_tomado);
      chk("desvio ready", inst_ready, 1'b0);
      chk("desvio we", reg_we, 1'b0);
      @(posedge clock);
      #1;
      chk("desvio valido end", desvio_valido, 1'b0);
      chk("desvio tomado end", desvio_tomado, 1'b0);
      chk("desvio ready end", inst_ready, 1'b1);
    end
  endtask

  initial begin
    //            tipo   op        cond    rd     res       ZCSO     flags    tom   erro
    vecs[0]  = '{2'b00, 5'b00000, 3'b000, 4'd3,  16'h8000, 4'b0011, 4'b0011, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 5'b00000, 3'b000, 4'd0,  16'h0000, 4'b0000, 4'b0011, 1'b1, 1'b0};
    vecs[2]  = '{2'b01, 5'b00000, 3'b110, 4'd0,  16'h0000, 4'b0000, 4'b0011, 1'b1, 1'b0};
    vecs[3]  = '{2'b01, 5'b00000, 3'b011, 4'd0,  16'h0000, 4'b0000, 4'b0011, 1'b1, 1'b0};
    vecs[4]  = '{2'b01, 5'b00000, 3'b100, 4'd0,  16'h0000, 4'b0000, 4'b0011, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 5'b10001, 3'b000, 4'd5,  16'h0000, 4'b1101, 4'b1000, 1'b0, 1'b0};
    vecs[6]  = '{2'b01, 5'b00000, 3'b001, 4'd0,  16'h0000, 4'b0000, 4'b1000, 1'b1, 1'b0};
    vecs[7]  = '{2'b01, 5'b00000, 3'b101, 4'd0,  16'h0000, 4'b0000, 4'b1000, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 5'b00000, 3'b010, 4'd0,  16'h0000, 4'b0000, 4'b1000, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 5'b01000, 3'b000, 4'd7,  16'hFFFE, 4'b0111, 4'b0110, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 5'b00000, 3'b111, 4'd0,  16'h0000, 4'b0000, 4'b0110, 1'b1, 1'b0};
    vecs[11] = '{2'b01, 5'b00000, 3'b101, 4'd0,  16'h0000, 4'b0000, 4'b0110, 1'b1, 1'b0};
    vecs[12] = '{2'b00, 5'b00111, 3'b000, 4'd9,  16'h1234, 4'b1111, 4'b0110, 1'b0, 1'b1};
    vecs[13] = '{2'b00, 5'b01100, 3'b000, 4'd9,  16'h1234, 4'b1111, 4'b0110, 1'b0, 1'b1};
    vecs[14] = '{2'b00, 5'b00010, 3'b000, 4'd9,  16'h1234, 4'b1111, 4'b0110, 1'b0, 1'b1};
    vecs[15] = '{2'b10, 5'b00000, 3'b001, 4'd0,  16'h0000, 4'b0000, 4'b0110, 1'b1, 1'b0};
    vecs[16] = '{2'b11, 5'b00000, 3'b000, 4'd1,  16'hABCD, 4'b1111, 4'b0110, 1'b0, 1'b0};
    vecs[17] = '{2'b00, 5'b00011, 3'b000, 4'd15, 16'h7FFF, 4'b0101, 4'b0101, 1'b0, 1'b0};
    vecs[18] = '{2'b01, 5'b00000, 3'b111, 4'd0,  16'h0000, 4'b0000, 4'b0101, 1'b1, 1'b0};
    vecs[19] = '{2'b01, 5'b00000, 3'b110, 4'd0,  16'h0000, 4'b0000, 4'b0101, 1'b1, 1'b0};
    vecs[20] = '{2'b01, 5'b00000, 3'b010, 4'd0,  16'h0000, 4'b0000, 4'b0101, 1'b1, 1'b0};
    vecs[21] = '{2'b00, 5'b11111, 3'b000, 4'd2,  16'h0000, 4'b1111, 4'b1010, 1'b0, 1'b0};
    vecs[22] = '{2'b01, 5'b00000, 3'b111, 4'd0,  16'h0000, 4'b0000, 4'b1010, 1'b1, 1'b0};
    vecs[23] = '{2'b01, 5'b00000, 3'b100, 4'd0,  16'h0000, 4'b0000, 4'b1010, 1'b0, 1'b0};
    vecs[24] = '{2'b00, 5'b01001, 3'b000, 4'd6,  16'h4001, 4'b0111, 4'b0110, 1'b0, 1'b0};

    reset       = 1'b1;
    inst_valid  = 1'b0;
    inst_tipo   = 2'b11;
    inst_op     = 5'b00000;
    inst_cond   = 3'b000;
    inst_rd     = 4'd0;
    resultadoOp = 16'h0000;
    {Z, C, S, O} = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    chk("reset ready", inst_ready, 1'b1);
    chk("reset controle", controle, 5'b10000);
    chk("reset flags", flags, 4'b0000);
    chk("reset end", reg_end, 4'd0);
    chk("reset dado", reg_dado, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk("idle ready", inst_ready, 1'b1);
      chk("idle controle", controle, 5'b10000);
      chk("idle flags", flags, 4'b0000);
      chk("idle we", reg_we, 1'b0);
      chk("idle valido", desvio_valido, 1'b0);
      chk("idle erro", erro_op, 1'b0);
    end

    for (int i = 0; i < NV; i++) aplica(vecs[i]);

    // Abort during EXECUTA: flags were 0110 before, must drop to reset value with no write.
    @(negedge clock);
    inst_valid  = 1'b1;
    inst_tipo   = 2'b00;
    inst_op     = 5'b00001;
    inst_rd     = 4'd11;
    resultadoOp = 16'h5555;
    {Z, C, S, O} = 4'b1111;
    @(posedge clock);
    #1;
    inst_valid = 1'b0;
    chk("abort in execute", controle, 5'b00001);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort we", reg_we, 1'b0);
    chk("abort flags", flags, 4'b0000);
    chk("abort ready", inst_ready, 1'b1);
    chk("abort controle", controle, 5'b10000);
    chk("abort end", reg_end, 4'd0);
    @(posedge clock);
    #1;
    chk("abort we2", reg_we, 1'b0);
    chk("abort flags2", flags, 4'b0000);
    aplica('{2'b11, 5'b00000, 3'b000, 4'd4, 16'h1111, 4'b1111, 4'b0000, 1'b0, 1'b0});
    @(posedge clock);
    #1;
    chk("nop quiet we", reg_we, 1'b0);
    chk("nop quiet valido", desvio_valido, 1'b0);
    chk("nop quiet ready", inst_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_sequenciador.md
Name: ula_sequenciador

Overview:
- Issuing end of the ALU interface: accepts decoded ALU/branch instructions and drives the 5-bit ALU function code.
- Samples the combinational ALU result and Z/C/S/O flags, then writes the result back to the register file.
- Holds the architectural flag register and evaluates conditional jumps against it.
- Sits between instruction decode and the ALU/register file in the 16-bit datapath.

Parameters:
bits_palavra, 16, datapath word width
bits_controle, 5, ALU function code width
bits_end, 4, register-file destination address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
inst_valid  in  1  instruction offered
inst_ready  out  1  sequencer can accept an instruction
inst_tipo  in  2  00 ALU op, 01 conditional jump, 10 unconditional jump, 11 NOP
inst_op  in  bits_controle  ALU function code (when inst_tipo=00)
inst_cond  in  3  jump condition (when inst_tipo=01)
inst_rd  in  bits_end  destination register
controle  out  bits_controle  function code to ALU
resultadoOp  in  bits_palavra  ALU result
Z, C, S, O  in  1 each  ALU flags
reg_we  out  1  register-file write strobe
reg_end  out  bits_end  write address
reg_dado  out  bits_palavra  write data
flags  out  4  flag register {Z,C,S,O}
desvio_valido  out  1  jump decision valid
desvio_tomado  out  1  jump taken
erro_op  out  1  unsupported ALU code pulse

Behaviour:
- Reset (synchronous, active-high): state OCIOSO; flags=0000; reg_we, desvio_valido, desvio_tomado, erro_op=0; reg_end=0; reg_dado=0; controle=10000.
- Reset mid-operation aborts the instruction: no reg_we, and flags hold their reset value.
- FSM states: OCIOSO, EXECUTA, GRAVA, AVALIA.
- inst_ready=1 only in OCIOSO, including in the cycle after reset.
- Handshake: the instruction is accepted on a rising edge with inst_valid && inst_ready, and inst_op/inst_cond/inst_rd are captured on that edge.
- OCIOSO, on accept:
  - ALU op, valid code → EXECUTA.
  - ALU op, invalid code → erro_op=1 for one cycle; remain in OCIOSO; flags and register file untouched. Invalid codes are 00010, 00111, 01010–01111.
  - Conditional or unconditional jump → AVALIA.
  - NOP → remain in OCIOSO; no side effects.
- controle = captured inst_op in EXECUTA, and 10000 in every other state.
- EXECUTA lasts 1 cycle, ending with EXECUTA→GRAVA. On its closing edge:
  - resultadoOp is latched into reg_dado and inst_rd into reg_end.
  - Arithmetic codes 00xxx: flags ← {Z,C,S,O} from the ALU.
  - Shift codes 0100x: flags ← {Z,C,S,0}.
  - Logic codes 1xxxx: flags ← {Z,0,S,0}.
- GRAVA: reg_we=1 for exactly one cycle, then → OCIOSO.
  - ALU latency: accepted on edge k, reg_we high in cycle k+2, next accept possible on edge k+3.
- AVALIA: desvio_valido=1 for exactly one cycle, then → OCIOSO.
  - Unconditional jump: desvio_tomado=1.
  - Conditional jump, against the current flag register:
    - 000: always
    - 001: Z
    - 010: !Z
    - 011: S
    - 100: !S
    - 101: C
    - 110: O
    - 111: S^O (signed less-than)
  - Flags written by an immediately preceding ALU op are visible (they were committed at the end of that op's EXECUTA).
- desvio_tomado=0 whenever desvio_valido=0.
- inst_* changes while inst_ready=0 are ignored.

Test Plan:
- Reset then idle → inst_ready=1, controle=10000, flags=0000, reg_we=0 throughout.
- ALU op 00000, rd=3, bench ALU returns 0x8000 with Z=0,C=0,S=1,O=1 → controle=00000 for 1 cycle; reg_we=1, reg_end=3, reg_dado=0x8000 at k+2; flags=0011.
- Logic op 10001 returning 0x0000 with C=1,O=1 at the ALU, followed back-to-back by jump cond 001 → flags=1000; desvio_valido=1, desvio_tomado=1; then cond 101 → desvio_tomado=0.
- Shift 01000 returning 0xFFFE with C=1, then cond 111 with prior flags S=1,O=0 → flags=0110; desvio_tomado=1.
- Invalid op 00111 → erro_op pulse for 1 cycle, no reg_we, flags unchanged, inst_ready stays 1.
- Reset asserted during EXECUTA → no reg_we, flags=0000 next cycle, inst_ready=1; a NOP accepted then produces no outputs.
